// File: rtl/svc_rv_mem_model.sv
// svc_rv_mem_model: behavioural instruction/data memory for a RISC-V core
// bench. It has a byte-strobed word store, a read latency of 0, 1 or 2
// cycles, and stall injection that can only hold a read that is already
// outstanding, for a bounded run of cycles.
module svc_rv_mem_model #(
    parameter int              DW          = 32,
    parameter int              AW          = 32,
    parameter int              WORDS       = 32,
    parameter int              LATENCY     = 1,
    parameter int              MAX_STALL   = 2,
    parameter logic [DW-1:0]   RESET_RDATA = DW'(32'h00000013),
    parameter int              CW          = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ren,
    input  logic [AW-1:0]      raddr,
    output logic [DW-1:0]      rdata,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [DW-1:0]      wdata,
    input  logic [DW/8-1:0]    wstrb,
    input  logic               stall_req,
    output logic               stall,
    output logic [CW-1:0]      stall_total
);

    localparam int         IW          = $clog2(WORDS);
    localparam int         SW          = DW / 32'sd8;
    localparam int         BW          = 32'sd8;
    localparam logic [1:0] MAX_STALL_C = 2'(MAX_STALL);

    // Merge the strobed bytes of a new word into the old word.
    function automatic logic [DW-1:0] merge_bytes(
        input logic [DW-1:0] old_w,
        input logic [DW-1:0] new_w,
        input logic [SW-1:0] strb
    );
        logic [DW-1:0] res;
        res = old_w;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) begin
                res[b*BW +: BW] = new_w[b*BW +: BW];
            end else begin
                res[b*BW +: BW] = old_w[b*BW +: BW];
            end
        end
        return res;
    endfunction

    // Backing store is deliberately not reset.
    logic [DW-1:0] mem [WORDS];

    logic [IW-1:0] ridx_s;
    logic [IW-1:0] widx_s;
    logic [DW-1:0] mem_rd_s;
    logic          pending_s;
    logic          stall_s;
    logic          rd_acc_s;
    logic          wr_acc_s;
    logic          unused_addr_s;

    logic [1:0]    run_cnt_q;
    logic [1:0]    run_cnt_d;
    logic [CW-1:0] stall_total_q;
    logic [CW-1:0] stall_total_d;

    // Bits below the word offset and above the index are ignored, so the
    // address space wraps modulo WORDS*4 bytes.
    assign ridx_s        = raddr[IW+1:2];
    assign widx_s        = waddr[IW+1:2];
    assign unused_addr_s = ^{raddr, waddr};

    // Reading mem before the write edge gives old data on a same-index collision.
    assign mem_rd_s = mem[ridx_s];

    // A stall may only hold an outstanding read and is capped at MAX_STALL cycles.
    assign stall_s  = stall_req & pending_s & (run_cnt_q < MAX_STALL_C);
    assign rd_acc_s = ren & ~stall_s;
    assign wr_acc_s = we & ~stall_s;

    assign stall       = stall_s;
    assign stall_total = stall_total_q;

    // Byte-strobed write into the backing store on an accepted write.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem[widx_s] <= merge_bytes(mem[widx_s], wdata, wstrb);
        end
    end

    // Next values for the stall run length and the saturating stall counter.
    always_comb begin
        run_cnt_d     = run_cnt_q;
        stall_total_d = stall_total_q;
        if (stall_s) begin
            if (run_cnt_q < MAX_STALL_C) begin
                run_cnt_d = run_cnt_q + 2'd1;
            end else begin
                run_cnt_d = run_cnt_q;
            end
            if (stall_total_q != {CW{1'b1}}) begin
                stall_total_d = stall_total_q + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                stall_total_d = stall_total_q;
            end
        end else begin
            run_cnt_d     = 2'd0;
            stall_total_d = stall_total_q;
        end
    end

    // Stall bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q     <= 2'd0;
            stall_total_q <= '0;
        end else begin
            run_cnt_q     <= run_cnt_d;
            stall_total_q <= stall_total_d;
        end
    end

    if (LATENCY == 32'sd0) begin : g_lat0
        // SRAM-like: the read is outstanding exactly while ren is high.
        assign pending_s = ren;
        assign rdata     = ren ? mem_rd_s : {DW{1'b0}};
    end else begin : g_seq
        logic          pending_q;
        logic          pending_d;
        logic [DW-1:0] s1_q;
        logic [DW-1:0] s1_d;
        logic [DW-1:0] rdata_q;
        logic [DW-1:0] rdata_d;

        assign pending_s = pending_q;
        assign rdata     = rdata_q;

        // Pending is set by an accepted read and dropped by an idle unstalled cycle.
        always_comb begin
            pending_d = pending_q;
            if (rd_acc_s) begin
                pending_d = 1'b1;
            end else if (!stall_s) begin
                pending_d = 1'b0;
            end else begin
                pending_d = pending_q;
            end
        end

        // Read pipeline: one stage for LATENCY 1, two stages for LATENCY 2.
        always_comb begin
            s1_d    = s1_q;
            rdata_d = rdata_q;
            if (LATENCY == 32'sd1) begin
                s1_d = s1_q;
                if (rd_acc_s) begin
                    rdata_d = mem_rd_s;
                end else begin
                    rdata_d = rdata_q;
                end
            end else begin
                if (rd_acc_s) begin
                    s1_d = mem_rd_s;
                end else begin
                    s1_d = s1_q;
                end
                if (!stall_s) begin
                    rdata_d = s1_q;
                end else begin
                    rdata_d = rdata_q;
                end
            end
        end

        // Read pipeline and pending registers; an in-flight read is dropped on reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pending_q <= 1'b0;
                s1_q      <= RESET_RDATA;
                rdata_q   <= RESET_RDATA;
            end else begin
                pending_q <= pending_d;
                s1_q      <= s1_d;
                rdata_q   <= rdata_d;
            end
        end
    end

endmodule
